// File: rtl/ifetch_pkg.sv
// Shared types and default widths for the instruction-fetch unit.
package ifetch_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STALL_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;
endpackage

// File: rtl/ifetch_stall_ctr.sv
// Saturating stall-cycle counter: advances by one per enabled cycle and sticks at all-ones.
module ifetch_stall_ctr
    import ifetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [STALL_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {STALL_W{1'b1}})) begin
            count <= count + STALL_W'(1);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch: issues one memory request per fetch_start,
// captures the response into the instruction register and holds it until consumed.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               fetch_start,
    input  logic               flush,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [DATA_W-1:0]  imem_rsp_data,
    output logic [DATA_W-1:0]  ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_consume,
    output logic               busy,
    output logic               misaligned,
    output logic [STALL_W-1:0] stall_cycles
);
    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc_lat;
    logic              flush_seen;
    logic              start_ok, start_bad;
    logic              launch, capture, mis_nxt;
    logic              stall_en;

    assign start_ok  = fetch_start && (pc_in[1:0] == 2'b00);
    assign start_bad = fetch_start && (pc_in[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        capture   = 1'b0;
        mis_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = REQ;
                    launch    = 1'b1;
                end else if (start_bad) begin
                    mis_nxt = 1'b1;
                end
            end
            REQ: begin
                // The request cannot be withdrawn, so a flush seen while waiting
                // for ready only redirects the eventual response into DRAIN.
                if (imem_req_ready) begin
                    state_nxt = (flush || flush_seen) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = imem_rsp_valid ? IDLE : DRAIN;
                end else if (imem_rsp_valid) begin
                    state_nxt = HOLD;
                    capture   = 1'b1;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (ir_consume) begin
                    if (start_ok) begin
                        state_nxt = REQ;
                        launch    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        mis_nxt   = start_bad;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_lat     <= '0;
            ir_out     <= '0;
            ir_pc      <= '0;
            misaligned <= 1'b0;
            flush_seen <= 1'b0;
        end else begin
            state      <= state_nxt;
            misaligned <= mis_nxt;
            flush_seen <= (state == REQ) && !imem_req_ready && (flush_seen || flush);
            if (launch) begin
                pc_lat <= pc_in;
            end
            if (capture) begin
                ir_out <= imem_rsp_data;
                ir_pc  <= pc_lat;
            end
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc_lat;
    assign ir_valid       = (state == HOLD);
    assign busy           = (state == REQ) || (state == WAIT) || (state == DRAIN);
    assign stall_en       = ((state == REQ) && !imem_req_ready) || (state == WAIT);

    ifetch_stall_ctr u_stall_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en),
        .count (stall_cycles)
    );
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a response scoreboard for captured instructions.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        fetch_start, flush;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] ir_out, ir_pc;
    logic        ir_valid, ir_consume;
    logic        busy, misaligned;
    logic [15:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } ir_exp_t;
    ir_exp_t sb[$];

    always #5 clk = ~clk;

    ifetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_in          (pc_in),
        .fetch_start    (fetch_start),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ir_out         (ir_out),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .ir_consume     (ir_consume),
        .busy           (busy),
        .misaligned     (misaligned),
        .stall_cycles   (stall_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive_rsp(input logic [31:0] d, input logic [31:0] pc, input bit expect_capture);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        if (expect_capture) sb.push_back({d, pc});
    endtask

    task automatic check_ir(input string name);
        ir_exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed ir_valid=%0b with empty scoreboard, required an expected entry", name, ir_valid);
        end else begin
            e = sb.pop_front();
            check({name, ".valid"}, ir_valid, 1);
            check({name, ".data"}, ir_out, e.data);
            check({name, ".pc"}, ir_pc, e.pc);
        end
    endtask

    task automatic start_fetch(input logic [31:0] pc);
        pc_in       = pc;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pc_in = '0; fetch_start = 0; flush = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = '0; ir_consume = 0;
        #3;
        check("rst.req_valid", imem_req_valid, 0);
        check("rst.req_addr", imem_req_addr, 0);
        check("rst.ir_out", ir_out, 0);
        check("rst.ir_pc", ir_pc, 0);
        check("rst.ir_valid", ir_valid, 0);
        check("rst.misaligned", misaligned, 0);
        check("rst.stall", stall_cycles, 0);
        check("rst.busy", busy, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Minimum-latency fetch at 0x40
        imem_req_ready = 1'b1;
        start_fetch(32'h40);
        check("t1.req_valid", imem_req_valid, 1);
        check("t1.req_addr", imem_req_addr, 32'h40);
        check("t1.busy", busy, 1);
        step();
        check("t1.req_done", imem_req_valid, 0);
        check("t1.no_ir_yet", ir_valid, 0);
        drive_rsp(32'h8C220004, 32'h40, 1);
        step();
        imem_rsp_valid = 1'b0;
        check_ir("t1.ir");
        step(); step();
        check("t1.held", ir_valid, 1);
        check("t1.held_busy", busy, 0);
        ir_consume = 1'b1;
        step();
        ir_consume = 1'b0;
        check("t1.consumed", ir_valid, 0);
        check("t1.retain_out", ir_out, 32'h8C220004);
        check("t1.retain_pc", ir_pc, 32'h40);
        check("t1.stall", stall_cycles, 1);

        // Ready held low for three cycles; pc_in moves but the request must not
        imem_req_ready = 1'b0;
        start_fetch(32'h40);
        pc_in = 32'h99;
        for (int i = 0; i < 3; i++) begin
            check("t2.valid_held", imem_req_valid, 1);
            check("t2.addr_held", imem_req_addr, 32'h40);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        drive_rsp(32'h00A00093, 32'h40, 1);
        step();
        imem_rsp_valid = 1'b0;
        check_ir("t2.ir");
        check("t2.stall", stall_cycles, 5);
        ir_consume = 1'b1;
        step();
        ir_consume = 1'b0;

        // Flush in WAIT, late response discarded, then a clean fetch of 0x44
        start_fetch(32'h40);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3.drain_busy", busy, 1);
        drive_rsp(32'hDEADBEEF, 32'h40, 0);
        step();
        imem_rsp_valid = 1'b0;
        check("t3.discard_valid", ir_valid, 0);
        check("t3.discard_out", ir_out, 32'h00A00093);
        check("t3.idle", busy, 0);
        start_fetch(32'h44);
        check("t3.addr44", imem_req_addr, 32'h44);
        step();
        drive_rsp(32'h12345678, 32'h44, 1);
        step();
        imem_rsp_valid = 1'b0;
        check_ir("t3.ir");
        check("t3.stall", stall_cycles, 7);
        ir_consume = 1'b1;
        step();
        ir_consume = 1'b0;

        // Misaligned start
        start_fetch(32'h42);
        check("t4.mis_pulse", misaligned, 1);
        check("t4.no_req", imem_req_valid, 0);
        check("t4.not_busy", busy, 0);
        step();
        check("t4.mis_clear", misaligned, 0);
        check("t4.still_no_req", imem_req_valid, 0);

        // Back-to-back: consume plus aligned start in HOLD
        start_fetch(32'h40);
        step();
        drive_rsp(32'h11111111, 32'h40, 1);
        step();
        imem_rsp_valid = 1'b0;
        check_ir("t5.first");
        ir_consume = 1'b1;
        start_fetch(32'h48);
        ir_consume = 1'b0;
        check("t5.b2b_valid", imem_req_valid, 1);
        check("t5.b2b_addr", imem_req_addr, 32'h48);
        check("t5.b2b_ir_clear", ir_valid, 0);
        step();
        drive_rsp(32'h22222222, 32'h48, 1);
        step();
        imem_rsp_valid = 1'b0;
        check_ir("t5.second");
        check("t5.stall", stall_cycles, 9);
        ir_consume = 1'b1;
        step();
        ir_consume = 1'b0;

        // Asynchronous reset in the middle of WAIT
        start_fetch(32'h40);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t6.req_valid", imem_req_valid, 0);
        check("t6.req_addr", imem_req_addr, 0);
        check("t6.ir_out", ir_out, 0);
        check("t6.ir_pc", ir_pc, 0);
        check("t6.stall", stall_cycles, 0);
        check("t6.busy", busy, 0);
        step();
        rst_n = 1'b1;
        drive_rsp(32'hCAFEF00D, 32'h40, 0);
        step();
        imem_rsp_valid = 1'b0;
        check("t6.late_ignored", ir_valid, 0);
        check("t6.late_out", ir_out, 0);
        check("t6.late_idle", busy, 0);
        check("t6.sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
